// File: rtl/sign_extender_pkg.sv
// Shared core types: control-unit operation encoding used by the control unit,
// ALU and the immediate generator.
package sign_extender_pkg;

    localparam int unsigned ImmWidth = 20;
    localparam int unsigned OutWidth = 32;
    localparam int unsigned OpWidth  = 6;

    typedef enum logic [OpWidth-1:0] {
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
        CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SH, CU_SW,
        CU_ADDI, CU_SLTI, CU_SLTIU, CU_SLIU, CU_XORI, CU_ORI, CU_ANDI,
        CU_SLLI, CU_SRLI, CU_SRAI,
        CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
        CU_ERROR
    } cuOPType;

endpackage

// File: rtl/imm_formatter.sv
// Combinational immediate formatter: classifies CUOp into an instruction format
// and assembles the 32-bit immediate from the raw 20-bit field.
module imm_formatter
    import sign_extender_pkg::*;
(
    input  logic [ImmWidth-1:0] imm,
    input  cuOPType             CUOp,
    output logic [OutWidth-1:0] imm_fmt
);

    typedef enum logic [2:0] {
        FmtU, FmtJ, FmtB, FmtI, FmtS, FmtShamt, FmtNone
    } fmt_e;

    fmt_e fmt;

    always_comb begin
        fmt = FmtNone;
        case (CUOp)
            CU_LUI, CU_AUIPC:                                   fmt = FmtU;
            CU_JAL:                                             fmt = FmtJ;
            CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU:   fmt = FmtB;
            CU_JALR, CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
            CU_ADDI, CU_SLTI, CU_SLTIU, CU_SLIU,
            CU_XORI, CU_ORI, CU_ANDI:                           fmt = FmtI;
            CU_SB, CU_SH, CU_SW:                                fmt = FmtS;
            CU_SLLI, CU_SRLI, CU_SRAI:                          fmt = FmtShamt;
            // R-type, CU_ERROR and unassigned encodings produce zero
            default:                                            fmt = FmtNone;
        endcase
    end

    always_comb begin
        imm_fmt = '0;
        case (fmt)
            FmtU:     imm_fmt = {imm[19:0], 12'b0};
            // J and B fields arrive with the sign bit in the top position and the
            // LSB-side bit rotated out; rotate it back into bit 0.
            FmtJ:     imm_fmt = {{12{imm[19]}}, imm[18:0], imm[19]};
            FmtB:     imm_fmt = {{20{imm[11]}}, imm[10:0], imm[11]};
            FmtI,
            FmtS:     imm_fmt = {{20{imm[11]}}, imm[11:0]};
            FmtShamt: imm_fmt = {27'b0, imm[4:0]};
            default:  imm_fmt = '0;
        endcase
    end

endmodule

// File: rtl/sign_extender.sv
// Immediate generator: formats the raw immediate per CUOp and registers it,
// giving one cycle of latency with an asynchronous active-low clear.
module sign_extender
    import sign_extender_pkg::*;
(
    input  logic                clk,
    input  logic                nRst,
    input  logic [ImmWidth-1:0] imm,
    input  cuOPType             CUOp,
    output logic [OutWidth-1:0] immOut
);

    logic [OutWidth-1:0] imm_d;

    imm_formatter u_imm_formatter (
        .imm     (imm),
        .CUOp    (CUOp),
        .imm_fmt (imm_d)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            immOut <= '0;
        end else begin
            immOut <= imm_d;
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
// Self-checking bench for sign_extender: directed vectors, async reset and
// randomized ops/immediates against an arithmetic reference model.
module tb_sign_extender;
    import sign_extender_pkg::*;

    logic        clk;
    logic        nRst;
    logic [19:0] imm;
    cuOPType     CUOp;
    logic [31:0] immOut;

    int errors = 0;
    int checks = 0;

    sign_extender dut (
        .clk    (clk),
        .nRst   (nRst),
        .imm    (imm),
        .CUOp   (CUOp),
        .immOut (immOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: format chosen from the position of op in the encoding list.
    function automatic logic [31:0] model(input int op, input logic [19:0] v);
        logic [31:0] r;
        logic [11:0] lo;
        lo = v[11:0];
        if (op <= 1) begin
            r = 32'(v) << 12;
        end else if (op == 2) begin
            r = ((32'(v) << 1) | (32'(v) >> 19)) & 32'h000F_FFFF;
            if (v[19]) r = r | 32'hFFF0_0000;
        end else if (op >= 4 && op <= 9) begin
            r = ((32'(lo) << 1) | (32'(lo) >> 11)) & 32'h0000_0FFF;
            if (lo[11]) r = r | 32'hFFFF_F000;
        end else if (op == 3 || (op >= 10 && op <= 24)) begin
            r = 32'(lo);
            if (lo[11]) r = r - 32'h0000_1000;
        end else if (op >= 25 && op <= 27) begin
            r = 32'(v) % 32;
        end else begin
            r = 32'h0;
        end
        return r;
    endfunction

    task automatic drive(input int op, input logic [19:0] v);
        @(negedge clk);
        CUOp = cuOPType'(op[5:0]);
        imm  = v;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        imm  = 20'hCCCCC;
        CUOp = CU_LUI;
        #1;
        checks++;
        if (immOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_initial: got %h want 00000000", immOut);
        end
        for (int i = 0; i < 3; i++) begin
            drive(i, 20'(($urandom | 32'h80000)));
            @(posedge clk); #1;
            checks++;
            if (immOut !== 32'h0) begin
                errors++;
                $display("FAIL reset_held[%0d]: got %h want 00000000", i, immOut);
            end
        end
        @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic test_vectors();
        int          ops [11];
        logic [19:0] ims [11];
        logic [31:0] exp [11];
        logic [31:0] prev;
        ops = '{6, 2, 11, 16, 12, 0, 1, 25, 28, 38, 50};
        ims = '{20'hCCCCC, 20'hCCCCC, 20'hCCCCC, 20'hCCCCC, 20'h00123, 20'hCCCCC,
                20'hCCCCC, 20'hFFFFF, 20'hCCCCC, 20'hCCCCC, 20'hCCCCC};
        exp = '{32'hFFFF_F999, 32'hFFF9_9999, 32'hFFFF_FCCC, 32'hFFFF_FCCC,
                32'h0000_0123, 32'hCCCC_C000, 32'hCCCC_C000, 32'h0000_001F,
                32'h0, 32'h0, 32'h0};
        drive(38, 20'h0);
        @(posedge clk); #1;
        prev = immOut;
        for (int i = 0; i < 11; i++) begin
            drive(ops[i], ims[i]);
            #1;
            checks++;
            if (immOut !== prev) begin
                errors++;
                $display("FAIL vec_early[%0d] op=%0d: got %h want %h", i, ops[i], immOut, prev);
            end
            @(posedge clk); #1;
            checks++;
            if (immOut !== exp[i]) begin
                errors++;
                $display("FAIL vec[%0d] op=%0d imm=%h: got %h want %h",
                         i, ops[i], ims[i], immOut, exp[i]);
            end
            prev = immOut;
        end
    endtask

    task automatic test_async_reset();
        drive(0, 20'hABCDE);
        @(posedge clk); #1;
        checks++;
        if (immOut !== 32'hABCD_E000) begin
            errors++;
            $display("FAIL pre_reset_load: got %h want abcde000", immOut);
        end
        #2;
        nRst = 1'b0;
        #1;
        checks++;
        if (immOut !== 32'h0) begin
            errors++;
            $display("FAIL async_clear: got %h want 00000000", immOut);
        end
        drive(2, 20'h87654);
        nRst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (immOut !== model(2, 20'h87654)) begin
            errors++;
            $display("FAIL first_after_reset: got %h want %h", immOut, model(2, 20'h87654));
        end
    endtask

    task automatic test_random();
        int          op;
        logic [19:0] v;
        logic [31:0] want;
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 63));
            v  = 20'($urandom);
            drive(op, v);
            want = model(op, v);
            @(posedge clk); #1;
            checks++;
            if (immOut !== want) begin
                errors++;
                $display("FAIL random[%0d] op=%0d imm=%h: got %h want %h", i, op, v, immOut, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
